xctcmsg_channel_mailbox: RTL and testbench
==========================================

# xctcmsg_channel_mailbox

Multi-channel receive mailbox for the XCTCMSG message unit, generalising the single-queue mailbox to NUM_CHANNELS independent per-channel FIFOs. Incoming network messages are steered by channel number. A core-side request port retrieves messages in one of four modes: blocking receive, non-blocking try, peek, and occupancy query. The block sits between the network adapter/loopback path and the writeback arbiter.

## Interface
- NUM_CHANNELS, 4, number of independent channels (≥1)
- DEPTH, 4, message slots per channel (≥1)
- DATA_WIDTH, 64, payload width
- Derived: CW = max(1,$clog2(NUM_CHANNELS)); NW = $clog2(DEPTH+1)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- flush  in  1  abort pending request; stored messages kept
- net_valid  in  1  network message valid
- net_ready  out  1  message accepted this cycle
- net_channel  in  CW  destination channel
- net_source  in  32  sender address
- net_data  in  DATA_WIDTH  payload
- req_valid  in  1  core request valid
- req_ready  out  1  request accepted
- req_mode  in  2  0 RECV (blocking), 1 TRY, 2 PEEK, 3 AVAIL
- req_channel  in  CW  channel to query
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumed
- rsp_success  out  1  message/count delivered
- rsp_source  out  32  sender of returned message
- rsp_data  out  DATA_WIDTH  payload or zero-extended count
- drop_count  out  16  saturating count of network messages to invalid channels

## Operation
- Storage: per channel, a circular buffer of DEPTH entries {source, data}, with head/tail pointers wrapping at DEPTH and an NW-bit count.
- Network push: for a valid channel, net_ready = (count < DEPTH). Push on net_valid && net_ready. For channel ≥ NUM_CHANNELS, net_ready = 1 and the message is discarded; drop_count increments and saturates at 0xFFFF.
- Request FSM states are IDLE, EVAL and RESP.
  - IDLE: req_ready = 1. On handshake, register mode and channel, then go to EVAL.
  - EVAL: decide using registered counts and go to RESP, except RECV on an empty channel, which stays in EVAL.
  - RESP: rsp_valid = 1 and outputs are held stable. On rsp_ready, go to IDLE.
- EVAL results:
  - RECV, non-empty: return head with success = 1 and pop.
  - TRY, non-empty: same as RECV.
  - TRY, empty: success = 0, data = 0, source = 0.
  - PEEK: return head without popping; if empty, return as TRY empty.
  - AVAIL: data = zero-extended count, success = 1, source = 0.
  - Any request to an invalid channel: success = 0, zero data, no wait.
- A pop takes effect in the EVAL→RESP transition cycle.
- A push and a pop on the same channel in the same cycle are both performed; the count is unchanged.
- Full channel with a simultaneous pop: net_ready stays 0 that cycle (no bypass).
- Flush has priority in every state.
  - The FSM goes to IDLE next cycle and rsp_valid deasserts.
  - No pop is performed in the flush cycle.
  - Network pushes continue normally during flush.
- Reset clears all pointers, counts, drop_count and response registers; the FSM enters IDLE.

## Timing
- Reset values:
  - req_ready = 1
  - net_ready = 1
  - rsp_valid = 0
  - rsp_success = 0
  - rsp_source = 0
  - rsp_data = 0
  - drop_count = 0
- Request accepted at cycle T. EVAL occurs at T+1. Earliest rsp_valid is T+2.
- Throughput is at most one request per 3 cycles with rsp_ready held high.
- A message pushed at cycle T is visible to EVAL at T+1 or later. A blocking RECV waiting on that channel responds at T+2.
- net_ready is combinational from registered count and net_channel. No other output depends combinationally on inputs.
- Response outputs are stable while rsp_valid && !rsp_ready.

## Test plan
- Reset, then push 3 messages to channel 2 (source 0x10/0x11/0x12, data 0xA/0xB/0xC) → three RECVs on ch2 return the same values in FIFO order with success = 1; AVAIL ch2 then returns 0.
- Fill ch1 with DEPTH = 4 messages → net_ready = 0 on a 5th push. RECV ch1 pops; the 5th message is accepted the cycle after the pop. Repeat 3 times to verify pointer wrap-around and ordering.
- Blocking RECV on empty ch0; push (0x20, 0x55) at cycle T → rsp_valid at T+2 with data 0x55; ch0 count back to 0.
- TRY on empty ch3 → success = 0, data 0 at T+2. PEEK twice on ch3 after one push → identical data both times; AVAIL ch3 = 1.
- RECV pending in EVAL; flush asserted → IDLE next cycle, no response. A later push/RECV still works and stored messages are intact.
- NUM_CHANNELS = 3, push to channel 3 → accepted and discarded, drop_count = 1. RECV ch3 → immediate success = 0. Hold rsp_ready low for 5 cycles → outputs stable.

Source files
------------

// File: rtl/xctcmsg_channel_mailbox.sv
// Multi-channel receive mailbox: per-channel message FIFOs filled from the network side and
// drained by a core-side request FSM (blocking receive, try, peek, occupancy query).
module xctcmsg_channel_mailbox #(
   parameter int unsigned NUM_CHANNELS = 4,
   parameter int unsigned DEPTH        = 4,
   parameter int unsigned DATA_WIDTH   = 64,
   localparam int unsigned CW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
   localparam int unsigned NW = $clog2(DEPTH + 1)
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_flush,
   input  logic                  i_net_valid,
   output logic                  o_net_ready,
   input  logic [CW-1:0]         i_net_channel,
   input  logic [31:0]           i_net_source,
   input  logic [DATA_WIDTH-1:0] i_net_data,
   input  logic                  i_req_valid,
   output logic                  o_req_ready,
   input  logic [1:0]            i_req_mode,
   input  logic [CW-1:0]         i_req_channel,
   output logic                  o_rsp_valid,
   input  logic                  i_rsp_ready,
   output logic                  o_rsp_success,
   output logic [31:0]           o_rsp_source,
   output logic [DATA_WIDTH-1:0] o_rsp_data,
   output logic [15:0]           o_drop_count
);

   localparam int unsigned     PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CW:0]     CH_LIM   = (CW + 1)'(NUM_CHANNELS);
   localparam logic [NW-1:0]   DEPTH_N  = NW'(DEPTH);
   localparam logic [PW-1:0]   LAST_PTR = PW'(DEPTH - 1);
   localparam logic [1:0]      MODE_RECV  = 2'd0;
   localparam logic [1:0]      MODE_TRY   = 2'd1;
   localparam logic [1:0]      MODE_AVAIL = 2'd3;

   typedef enum logic [1:0] {StIdle, StEval, StResp} state_e;

   logic [31:0]           r_src   [NUM_CHANNELS][DEPTH];
   logic [DATA_WIDTH-1:0] r_data  [NUM_CHANNELS][DEPTH];
   logic [PW-1:0]         r_head  [NUM_CHANNELS];
   logic [PW-1:0]         r_tail  [NUM_CHANNELS];
   logic [NW-1:0]         r_count [NUM_CHANNELS];

   state_e                r_state;
   logic [1:0]            r_mode;
   logic [CW-1:0]         r_chan;
   logic                  r_rsp_valid;
   logic                  r_rsp_success;
   logic [31:0]           r_rsp_source;
   logic [DATA_WIDTH-1:0] r_rsp_data;
   logic [15:0]           r_drop;

   logic                    w_net_ok;
   logic [CW-1:0]           w_net_idx;
   logic                    w_push;
   logic                    w_req_ok;
   logic [CW-1:0]           w_req_idx;
   logic                    w_empty;
   logic                    w_pop;
   logic [NUM_CHANNELS-1:0] w_push_ch;
   logic [NUM_CHANNELS-1:0] w_pop_ch;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == LAST_PTR) ? '0 : p + PW'(1);
   endfunction

   // Out-of-range channels are folded onto index 0 only to keep array reads in bounds.
   assign w_net_ok    = {1'b0, i_net_channel} < CH_LIM;
   assign w_net_idx   = w_net_ok ? i_net_channel : '0;
   assign o_net_ready = !w_net_ok || (r_count[w_net_idx] < DEPTH_N);
   assign w_push      = i_net_valid && w_net_ok && (r_count[w_net_idx] < DEPTH_N);

   assign w_req_ok  = {1'b0, r_chan} < CH_LIM;
   assign w_req_idx = w_req_ok ? r_chan : '0;
   assign w_empty   = (r_count[w_req_idx] == '0);
   assign w_pop     = (r_state == StEval) && !i_flush && w_req_ok && !w_empty &&
                      ((r_mode == MODE_RECV) || (r_mode == MODE_TRY));

   always_comb begin
      w_push_ch = '0;
      w_pop_ch  = '0;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
         w_push_ch[c] = w_push && (w_net_idx == CW'(c));
         w_pop_ch[c]  = w_pop && (w_req_idx == CW'(c));
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_push) begin
         r_src[w_net_idx][r_tail[w_net_idx]]  <= i_net_source;
         r_data[w_net_idx][r_tail[w_net_idx]] <= i_net_data;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int c = 0; c < NUM_CHANNELS; c++) begin
            r_head[c]  <= '0;
            r_tail[c]  <= '0;
            r_count[c] <= '0;
         end
         r_drop <= '0;
      end else begin
         for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (w_push_ch[c]) r_tail[c] <= ptr_inc(r_tail[c]);
            if (w_pop_ch[c])  r_head[c] <= ptr_inc(r_head[c]);
            case ({w_push_ch[c], w_pop_ch[c]})
               2'b10:   r_count[c] <= r_count[c] + NW'(1);
               2'b01:   r_count[c] <= r_count[c] - NW'(1);
               default: r_count[c] <= r_count[c];
            endcase
         end
         if (i_net_valid && !w_net_ok && (r_drop != 16'hFFFF)) r_drop <= r_drop + 16'd1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state       <= StIdle;
         r_mode        <= '0;
         r_chan        <= '0;
         r_rsp_valid   <= 1'b0;
         r_rsp_success <= 1'b0;
         r_rsp_source  <= '0;
         r_rsp_data    <= '0;
      end else if (i_flush) begin
         r_state     <= StIdle;
         r_rsp_valid <= 1'b0;
      end else begin
         unique case (r_state)
            StIdle: begin
               if (i_req_valid) begin
                  r_mode  <= i_req_mode;
                  r_chan  <= i_req_channel;
                  r_state <= StEval;
               end
            end
            StEval: begin
               if (!w_req_ok) begin
                  r_rsp_success <= 1'b0;
                  r_rsp_source  <= '0;
                  r_rsp_data    <= '0;
                  r_rsp_valid   <= 1'b1;
                  r_state       <= StResp;
               end else if (r_mode == MODE_AVAIL) begin
                  r_rsp_success <= 1'b1;
                  r_rsp_source  <= '0;
                  r_rsp_data    <= DATA_WIDTH'(r_count[w_req_idx]);
                  r_rsp_valid   <= 1'b1;
                  r_state       <= StResp;
               end else if (w_empty) begin
                  // Blocking receive parks here until the channel count goes non-zero.
                  if (r_mode != MODE_RECV) begin
                     r_rsp_success <= 1'b0;
                     r_rsp_source  <= '0;
                     r_rsp_data    <= '0;
                     r_rsp_valid   <= 1'b1;
                     r_state       <= StResp;
                  end
               end else begin
                  r_rsp_success <= 1'b1;
                  r_rsp_source  <= r_src[w_req_idx][r_head[w_req_idx]];
                  r_rsp_data    <= r_data[w_req_idx][r_head[w_req_idx]];
                  r_rsp_valid   <= 1'b1;
                  r_state       <= StResp;
               end
            end
            StResp: begin
               if (i_rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_state     <= StIdle;
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign o_req_ready   = (r_state == StIdle);
   assign o_rsp_valid   = r_rsp_valid;
   assign o_rsp_success = r_rsp_success;
   assign o_rsp_source  = r_rsp_source;
   assign o_rsp_data    = r_rsp_data;
   assign o_drop_count  = r_drop;

endmodule

// File: tb/tb_xctcmsg_channel_mailbox.sv
// Bench for xctcmsg_channel_mailbox: queue-based mailbox model checked every cycle, plus
// directed sequences with hand-computed payloads and latencies.
module tb_xctcmsg_channel_mailbox;

   localparam int NCH = 3;
   localparam int DEP = 4;
   localparam int DW  = 64;
   localparam int CW  = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          flush = 1'b0;
   logic          net_valid = 1'b0;
   logic [CW-1:0] net_channel = '0;
   logic [31:0]   net_source = '0;
   logic [DW-1:0] net_data = '0;
   logic          req_valid = 1'b0;
   logic [1:0]    req_mode = '0;
   logic [CW-1:0] req_channel = '0;
   logic          rsp_ready = 1'b1;
   logic          o_net_ready, o_req_ready, o_rsp_valid, o_rsp_success;
   logic [31:0]   o_rsp_source;
   logic [DW-1:0] o_rsp_data;
   logic [15:0]   o_drop_count;

   xctcmsg_channel_mailbox #(.NUM_CHANNELS(NCH), .DEPTH(DEP), .DATA_WIDTH(DW)) dut (
      .i_clk(clk), .i_rst(rst), .i_flush(flush),
      .i_net_valid(net_valid), .o_net_ready(o_net_ready), .i_net_channel(net_channel),
      .i_net_source(net_source), .i_net_data(net_data),
      .i_req_valid(req_valid), .o_req_ready(o_req_ready), .i_req_mode(req_mode),
      .i_req_channel(req_channel),
      .o_rsp_valid(o_rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_success(o_rsp_success),
      .o_rsp_source(o_rsp_source), .o_rsp_data(o_rsp_data), .o_drop_count(o_drop_count)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int bad = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- model ----------------
   typedef struct packed {
      logic [31:0] src;
      logic [63:0] data;
   } msg_t;

   msg_t        q [NCH][$];
   int          m_drop = 0;
   bit          m_out = 0;
   logic [1:0]  m_mode = '0;
   int          m_chan = 0;
   bit          pend_push = 0;
   bit          pend_drop = 0;
   int          pend_ch = 0;
   msg_t        pend_msg;
   bit          prev_valid = 0;
   bit          run_model = 0;
   logic        exp_succ = 1'b0;
   logic [31:0] exp_src = '0;
   logic [63:0] exp_data = '0;

   // Responses resolve against queue contents before the push landing on the same edge.
   always @(negedge clk) begin
      if (run_model) begin
         bit exp_ready;
         if (o_rsp_valid && !prev_valid) begin
            if (!m_out) begin
               check("rsp_without_req", 64'(o_rsp_valid), 64'd0);
            end else begin
               m_out = 0;
               if (m_chan >= NCH) begin
                  exp_succ = 1'b0; exp_src = '0; exp_data = '0;
               end else if (m_mode == 2'd3) begin
                  exp_succ = 1'b1; exp_src = '0; exp_data = 64'(q[m_chan].size());
               end else if (q[m_chan].size() == 0) begin
                  exp_succ = 1'b0; exp_src = '0; exp_data = '0;
                  if (m_mode == 2'd0) check("recv_on_empty", 64'(o_rsp_valid), 64'd0);
               end else begin
                  exp_succ = 1'b1;
                  exp_src  = q[m_chan][0].src;
                  exp_data = q[m_chan][0].data;
                  if (m_mode != 2'd2) void'(q[m_chan].pop_front());
               end
            end
         end
         if (o_rsp_valid) begin
            check("rsp_success", 64'(o_rsp_success), 64'(exp_succ));
            check("rsp_source", 64'(o_rsp_source), 64'(exp_src));
            check("rsp_data", o_rsp_data, exp_data);
         end
         prev_valid = o_rsp_valid;
         if (flush) m_out = 0;
         if (pend_push) q[pend_ch].push_back(pend_msg);
         if (pend_drop && m_drop < 65535) m_drop++;
         pend_push = 0;
         pend_drop = 0;
         if (int'(net_channel) >= NCH) exp_ready = 1;
         else exp_ready = q[int'(net_channel)].size() < DEP;
         check("net_ready", 64'(o_net_ready), 64'(exp_ready));
         check("drop_count", 64'(o_drop_count), 64'(m_drop));
         if (net_valid && exp_ready) begin
            if (int'(net_channel) >= NCH) begin
               pend_drop = 1;
            end else begin
               pend_push = 1;
               pend_ch   = int'(net_channel);
               pend_msg  = '{src: net_source, data: net_data};
            end
         end
      end
   end

   // ---------------- drivers (entered and left at posedge+1) ----------------
   task automatic push(input int ch, input logic [31:0] s, input logic [63:0] d,
                       output int acc);
      net_channel = CW'(ch); net_source = s; net_data = d; net_valid = 1'b1;
      acc = -1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (o_net_ready) begin acc = cyc; break; end
      end
      if (acc < 0) check("push_timeout", 64'(o_net_ready), 64'd1);
      @(posedge clk); #1;
      net_valid = 1'b0;
   endtask

   task automatic issue(input logic [1:0] mode, input int ch, output int acc);
      req_mode = mode; req_channel = CW'(ch); req_valid = 1'b1;
      acc = -1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (o_req_ready) begin acc = cyc; break; end
      end
      if (acc < 0) check("req_timeout", 64'(o_req_ready), 64'd1);
      m_mode = mode; m_chan = ch; m_out = 1;
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   task automatic wait_rsp(output int rc, output logic s, output logic [31:0] src,
                           output logic [63:0] d);
      rc = -1; s = 1'b0; src = '0; d = '0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (o_rsp_valid) begin
            rc = cyc; s = o_rsp_success; src = o_rsp_source; d = o_rsp_data;
            break;
         end
      end
      if (rc < 0) begin
         check("rsp_timeout", 64'(o_rsp_valid), 64'd1);
         flush = 1'b1; @(posedge clk); #1; flush = 1'b0;
      end
      @(posedge clk); #1;
   endtask

   task automatic do_req(input string name, input logic [1:0] mode, input int ch,
                         input logic es, input logic [31:0] esrc, input logic [63:0] ed);
      int ac, rc;
      logic s;
      logic [31:0] src;
      logic [63:0] d;
      issue(mode, ch, ac);
      wait_rsp(rc, s, src, d);
      check({name, "_latency"}, 64'(rc - ac), 64'd2);
      check({name, "_success"}, 64'(s), 64'(es));
      check({name, "_source"}, 64'(src), 64'(esrc));
      check({name, "_data"}, d, ed);
   endtask

   initial begin
      int pc, ac, rc;
      logic s;
      logic [31:0] src;
      logic [63:0] d;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_req_ready", 64'(o_req_ready), 64'd1);
      check("rst_net_ready", 64'(o_net_ready), 64'd1);
      check("rst_rsp_valid", 64'(o_rsp_valid), 64'd0);
      check("rst_rsp_success", 64'(o_rsp_success), 64'd0);
      check("rst_rsp_source", 64'(o_rsp_source), 64'd0);
      check("rst_rsp_data", o_rsp_data, 64'd0);
      check("rst_drop_count", 64'(o_drop_count), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      run_model = 1;

      // FIFO order on channel 2
      push(2, 32'h10, 64'hA, pc);
      push(2, 32'h11, 64'hB, pc);
      push(2, 32'h12, 64'hC, pc);
      do_req("recv2_a", 2'd0, 2, 1'b1, 32'h10, 64'hA);
      do_req("recv2_b", 2'd0, 2, 1'b1, 32'h11, 64'hB);
      do_req("recv2_c", 2'd0, 2, 1'b1, 32'h12, 64'hC);
      do_req("avail2", 2'd3, 2, 1'b1, 32'h0, 64'd0);

      // Full channel 1, back-pressure, pointer wrap
      for (int i = 0; i < 4; i++) push(1, 32'h100 + 32'(i), 64'h1000 + 64'(i), pc);
      net_channel = 2'd1; net_source = 32'h104; net_data = 64'h1004; net_valid = 1'b1;
      @(negedge clk);
      check("full_net_ready", 64'(o_net_ready), 64'd0);
      @(posedge clk); #1;
      for (int k = 0; k < 3; k++) begin
         fork
            push(1, 32'h104 + 32'(k), 64'h1004 + 64'(k), pc);
            begin
               issue(2'd0, 1, ac);
               wait_rsp(rc, s, src, d);
            end
         join
         check("wrap_pop_data", d, 64'h1000 + 64'(k));
         check("accept_after_pop", 64'(pc), 64'(rc));
      end
      for (int k = 3; k < 7; k++)
         do_req("drain1", 2'd0, 1, 1'b1, 32'h100 + 32'(k), 64'h1000 + 64'(k));
      do_req("avail1", 2'd3, 1, 1'b1, 32'h0, 64'd0);

      // Blocking RECV released by a later push
      fork
         begin
            issue(2'd0, 0, ac);
            wait_rsp(rc, s, src, d);
         end
         begin
            repeat (4) @(posedge clk);
            #1;
            push(0, 32'h20, 64'h55, pc);
         end
      join
      check("block_latency", 64'(rc - pc), 64'd2);
      check("block_data", d, 64'h55);
      check("block_source", 64'(src), 64'h20);
      do_req("avail0_a", 2'd3, 0, 1'b1, 32'h0, 64'd0);

      // TRY empty, PEEK twice, AVAIL
      do_req("try_empty", 2'd1, 0, 1'b0, 32'h0, 64'd0);
      push(0, 32'h30, 64'h77, pc);
      do_req("peek_a", 2'd2, 0, 1'b1, 32'h30, 64'h77);
      do_req("peek_b", 2'd2, 0, 1'b1, 32'h30, 64'h77);
      do_req("avail0_b", 2'd3, 0, 1'b1, 32'h0, 64'd1);

      // Flush a RECV parked on an empty channel
      issue(2'd0, 2, ac);
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("flush_rsp_valid", 64'(o_rsp_valid), 64'd0);
         check("flush_req_ready", 64'(o_req_ready), 64'd1);
      end
      @(posedge clk); #1;
      push(2, 32'h40, 64'h99, pc);
      repeat (2) @(posedge clk);
      #1;
      do_req("post_flush_recv", 2'd0, 2, 1'b1, 32'h40, 64'h99);
      do_req("intact_peek", 2'd2, 0, 1'b1, 32'h30, 64'h77);
      do_req("intact_recv", 2'd0, 0, 1'b1, 32'h30, 64'h77);

      // Invalid channel: drop, immediate failure, stall stability
      push(3, 32'hDEAD, 64'hBEEF, pc);
      @(negedge clk);
      check("drop_one", 64'(o_drop_count), 64'd1);
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      issue(2'd0, 3, ac);
      wait_rsp(rc, s, src, d);
      check("bad_ch_latency", 64'(rc - ac), 64'd2);
      check("bad_ch_success", 64'(s), 64'd0);
      check("bad_ch_data", d, 64'd0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("stall_valid", 64'(o_rsp_valid), 64'd1);
         check("stall_success", 64'(o_rsp_success), 64'd0);
         check("stall_data", o_rsp_data, 64'd0);
      end
      @(posedge clk); #1;
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      check("stall_release", 64'(o_rsp_valid), 64'd0);
      @(posedge clk); #1;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
